// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: size masks, FSM states, timeout default.
package mem_stage_pkg;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W           = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational store-lane replication, byte strobes and load extraction/extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_mask,
    input  logic        i_signed,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_read_word,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data
);

    // Low 16 bits of the read word after shifting the addressed byte down to lane 0.
    logic [15:0] w_lane;

    // Decode access size into lane data, strobes and the extended load value.
    always_comb begin
        w_lane      = 16'(i_read_word >> {i_offset, 3'b000});
        o_wdata     = i_store_data;
        o_wstrb     = 4'b1111;
        o_load_data = i_read_word;
        case (i_mask)
            MASK_B: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_wstrb     = 4'b0001 << i_offset;
                o_load_data = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
            end
            MASK_H: begin
                o_wdata     = {2{i_store_data[15:0]}};
                o_wstrb     = 4'b0011 << i_offset;
                o_load_data = {{16{i_signed & w_lane[15]}}, w_lane};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: input register, request/ready bus FSM with timeout,
// and write-back / forwarding outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic        readWr_i,
    input  logic        writeWr_i,
    input  logic [3:0]  rmask_i,
    input  logic [3:0]  wmask_i,
    input  logic        load_signed_i,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWr_i,
    input  logic [31:0] inst_debug_i,
    input  logic [31:0] pc_debug_i,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] regcData,
    output logic [4:0]  regcAddr,
    output logic        regcWr,
    output logic        mem_regWr,
    output logic [31:0] mem_data,
    output logic [4:0]  mem_regAddr,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] inst_debug,
    output logic [31:0] pc_debug
);

    // Abort fires on the TIMEOUT_CYCLES-th cycle spent in WAIT.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_addr, r_data, r_alu, r_inst, r_pc;
    logic [3:0]  r_rmask, r_wmask;
    logic [4:0]  r_rd_addr;
    logic        r_read, r_write, r_signed, r_alu_wr;
    logic        r_misalign, r_bus_err;
    state_t      r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    logic [3:0]  w_mask, w_wstrb;
    logic [31:0] w_wdata, w_load_data;
    logic        w_aligned, w_access, w_valid, w_misalign, w_abort, w_is_load;

    // Input register: holds the instruction while an access is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_alu     <= '0;
            r_inst    <= '0;
            r_pc      <= '0;
            r_rmask   <= '0;
            r_wmask   <= '0;
            r_rd_addr <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_signed  <= 1'b0;
            r_alu_wr  <= 1'b0;
        end else if (!stall) begin
            r_addr    <= memAddr_i;
            r_data    <= memData_i;
            r_alu     <= regcData_i;
            r_inst    <= inst_debug_i;
            r_pc      <= pc_debug_i;
            r_rmask   <= rmask_i;
            r_wmask   <= wmask_i;
            r_rd_addr <= regcAddr_i;
            r_read    <= readWr_i;
            r_write   <= writeWr_i;
            r_signed  <= load_signed_i;
            r_alu_wr  <= regcWr_i;
        end
    end

    // Access size and alignment; a store takes its size from wmask, a load from rmask.
    always_comb begin
        w_mask = r_write ? r_wmask : r_rmask;
        case (w_mask)
            MASK_H:  w_aligned = ~r_addr[0];
            MASK_W:  w_aligned = (r_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_access   = r_read | r_write;
    assign w_valid    = w_access & w_aligned;
    assign w_misalign = w_access & ~w_aligned;
    assign w_is_load  = r_read & ~r_write;

    mem_align u_align (
        .i_offset     (r_addr[1:0]),
        .i_mask       (w_mask),
        .i_signed     (r_signed),
        .i_store_data (r_data),
        .i_read_word  (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data)
    );

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, saturating counter and timeout abort; ready beats a same-cycle timeout.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid && !dmem_ready) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_ready) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt >= LAST_WAIT) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sticky fault flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_misalign) r_misalign <= 1'b1;
            if (w_abort)    r_bus_err  <= 1'b1;
        end
    end

    assign stall      = w_valid & ~dmem_ready & ~w_abort;
    assign dmem_req   = w_valid;
    assign dmem_we    = w_valid & r_write;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_wstrb = (w_valid & r_write) ? w_wstrb : 4'b0000;

    assign regcData    = w_is_load ? w_load_data : r_alu;
    assign regcAddr    = r_rd_addr;
    assign regcWr      = r_alu_wr & ~stall & ~w_misalign & ~w_abort;
    assign mem_regWr   = regcWr;
    assign mem_data    = regcData;
    assign mem_regAddr = regcAddr;
    assign misalign    = r_misalign;
    assign bus_err     = r_bus_err;
    assign inst_debug  = r_inst;
    assign pc_debug    = r_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage with an instruction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned TO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] alu;
        logic [31:0] rdv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [3:0]  mask;
        logic        rd;
        logic        wr;
        logic        sgn;
        logic        alu_wr;
        int          lat;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] memAddr_i, memData_i, regcData_i, inst_debug_i, pc_debug_i;
    logic        readWr_i, writeWr_i, load_signed_i, regcWr_i;
    logic [3:0]  rmask_i, wmask_i;
    logic [4:0]  regcAddr_i;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] regcData, mem_data, inst_debug, pc_debug;
    logic [4:0]  regcAddr, mem_regAddr;
    logic        regcWr, mem_regWr, misalign, bus_err;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .memAddr_i(memAddr_i), .memData_i(memData_i),
        .readWr_i(readWr_i), .writeWr_i(writeWr_i),
        .rmask_i(rmask_i), .wmask_i(wmask_i), .load_signed_i(load_signed_i),
        .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
        .inst_debug_i(inst_debug_i), .pc_debug_i(pc_debug_i),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .regcData(regcData), .regcAddr(regcAddr), .regcWr(regcWr),
        .mem_regWr(mem_regWr), .mem_data(mem_data), .mem_regAddr(mem_regAddr),
        .misalign(misalign), .bus_err(bus_err),
        .inst_debug(inst_debug), .pc_debug(pc_debug)
    );

    int passed = 0;
    int total  = 0;

    // Model state: instruction in the stage, cycles it has spent there, sticky flags.
    ins_t cur, nxt;
    int   cyc = 0;
    logic consumed = 1'b0;
    logic mis_seen = 1'b0, berr_seen = 1'b0;
    logic model_on = 1'b0;
    logic e_req, e_stall, e_wr, e_we, e_chk_data, e_mis, e_berr;
    logic [31:0] e_data, e_addr, e_wdata;
    logic [3:0]  e_strb;

    // Observations for directed checks; the "last" values are from the final cycle.
    int   o_stalls;
    logic o_wr_in_stall, o_req_seen, o_wr, o_we, o_mis, o_berr;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [3:0]  o_strb;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic int nbytes(logic [3:0] m);
        if (m == MASK_B) return 1;
        if (m == MASK_H) return 2;
        return 4;
    endfunction

    function automatic ins_t mk(logic rd, logic wr, logic [3:0] mask, logic [31:0] addr,
                                logic [31:0] data, logic [31:0] rdv, logic sgn,
                                logic alu_wr, logic [31:0] alu, int lat);
        ins_t i;
        i.rd = rd; i.wr = wr; i.mask = mask; i.addr = addr; i.data = data; i.rdv = rdv;
        i.sgn = sgn; i.alu_wr = alu_wr; i.alu = alu; i.lat = lat;
        i.rd_addr = 5'($urandom); i.inst = $urandom; i.pc = $urandom;
        return i;
    endfunction

    function automatic ins_t bubble();
        ins_t i;
        i = mk(1'b0, 1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0, '0, 0);
        i.rd_addr = '0; i.inst = '0; i.pc = '0;
        return i;
    endfunction

    function automatic ins_t filler();
        return mk(1'b0, 1'b0, MASK_W, $urandom, $urandom, $urandom, 1'b0, 1'b0, $urandom, 0);
    endfunction

    function automatic ins_t gen();
        int k, sz;
        logic [3:0] m;
        logic [31:0] a;
        k  = $urandom_range(0, 2);
        sz = $urandom_range(0, 2);
        m  = (sz == 0) ? MASK_B : (sz == 1) ? MASK_H : MASK_W;
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(m) - 1);
        return mk(k == 1, k == 2, m, a, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  (k == 1) ? 1'b1 : (k == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                  $urandom, $urandom_range(0, 6));
    endfunction

    task automatic drive(input ins_t i);
        memAddr_i     = i.addr;
        memData_i     = i.data;
        readWr_i      = i.rd;
        writeWr_i     = i.wr;
        rmask_i       = i.rd ? i.mask : 4'h0;
        wmask_i       = i.wr ? i.mask : 4'h0;
        load_signed_i = i.sgn;
        regcData_i    = i.alu;
        regcAddr_i    = i.rd_addr;
        regcWr_i      = i.alu_wr;
        inst_debug_i  = i.inst;
        pc_debug_i    = i.pc;
    endtask

    // One clock: present nxt, answer the bus for cur, predict outputs, advance the model.
    task automatic step();
        int sz, off;
        logic acc, valid, mis, rdy, abrt;
        logic [31:0] sh, v;
        @(negedge clk);
        drive(nxt);
        sz    = nbytes(cur.mask);
        off   = int'(cur.addr[1:0]);
        acc   = cur.rd || cur.wr;
        valid = acc && (off % sz == 0);
        mis   = acc && !valid;
        rdy   = valid && (cyc == cur.lat);
        abrt  = valid && !rdy && (cyc == int'(TO));
        dmem_ready = rdy;
        dmem_rdata = rdy ? cur.rdv : $urandom;
        e_req   = valid;
        e_stall = valid && !rdy && !abrt;
        e_wr    = !e_stall && cur.alu_wr && !mis && !abrt;
        e_we    = cur.wr;
        e_addr  = cur.addr - 32'(off);
        sh      = dmem_rdata >> (8 * off);
        if (sz == 1) begin
            v = sh & 32'hFF;
            if (cur.sgn && v[7]) v = v | 32'hFFFF_FF00;
            e_wdata = {24'h0, cur.data[7:0]} * 32'h0101_0101;
        end else if (sz == 2) begin
            v = sh & 32'hFFFF;
            if (cur.sgn && v[15]) v = v | 32'hFFFF_0000;
            e_wdata = {16'h0, cur.data[15:0]} * 32'h0001_0001;
        end else begin
            v = dmem_rdata;
            e_wdata = cur.data;
        end
        e_strb = 4'(cur.mask << off);
        if (cur.rd && !cur.wr) begin
            e_data = v; e_chk_data = e_wr;
        end else begin
            e_data = cur.alu; e_chk_data = 1'b1;
        end
        e_mis = mis_seen;
        e_berr = berr_seen;
        model_on = 1'b1;
        #3;
        if (stall) o_stalls++;
        if (stall && regcWr) o_wr_in_stall = 1'b1;
        if (dmem_req) o_req_seen = 1'b1;
        o_wr = regcWr; o_we = dmem_we; o_data = regcData; o_addr = dmem_addr;
        o_wdata = dmem_wdata; o_strb = dmem_wstrb; o_mis = misalign; o_berr = bus_err;
        @(posedge clk);
        consumed = !e_stall;
        if (mis) mis_seen = 1'b1;
        if (abrt) berr_seen = 1'b1;
        if (consumed) begin
            cur = nxt;
            cyc = 0;
        end else begin
            cyc++;
        end
    endtask

    task automatic issue(input ins_t i);
        nxt = i;
        consumed = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (consumed) break;
        end
        if (!consumed) begin
            total++;
            $display("FAIL issue_bound: instruction not accepted within 20 cycles");
        end
        nxt = filler();
    endtask

    task automatic run_cur();
        o_stalls = 0; o_wr_in_stall = 1'b0; o_req_seen = 1'b0;
        consumed = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (consumed) break;
        end
        if (!consumed) begin
            total++;
            $display("FAIL run_bound: instruction did not leave within 20 cycles");
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        #3;
        if (model_on) begin
            chk("stall", stall, e_stall);
            chk("dmem_req", dmem_req, e_req);
            chk("regcWr", regcWr, e_wr);
            chk("mem_regWr", mem_regWr, e_wr);
            if (e_chk_data) begin
                chk("regcData", regcData, e_data);
                chk("mem_data", mem_data, e_data);
            end
            chk("regcAddr", regcAddr, cur.rd_addr);
            chk("mem_regAddr", mem_regAddr, cur.rd_addr);
            if (e_req) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_we", dmem_we, e_we);
                if (e_we) begin
                    chk("dmem_wdata", dmem_wdata, e_wdata);
                    chk("dmem_wstrb", dmem_wstrb, e_strb);
                end
            end
            chk("misalign", misalign, e_mis);
            chk("bus_err", bus_err, e_berr);
            chk("inst_debug", inst_debug, cur.inst);
            chk("pc_debug", pc_debug, cur.pc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'hFFFF_FFFF;
        nxt = gen();
        drive(nxt);
        repeat (2) @(negedge clk);
        #3;
        chk("rst_regcData", regcData, 32'h0);
        chk("rst_regcWr", regcWr, 32'h0);
        chk("rst_stall", stall, 32'h0);
        chk("rst_dmem_req", dmem_req, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wstrb", dmem_wstrb, 32'h0);
        chk("rst_flags", {misalign, bus_err}, 32'h0);
        chk("rst_pc_debug", pc_debug, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        cur = bubble();
        cyc = 0;
        nxt = filler();

        // Word load, zero-wait.
        issue(mk(1'b1, 1'b0, MASK_W, 32'h100, '0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 0));
        run_cur();
        chk("wl_stalls", o_stalls, 32'd0);
        chk("wl_data", o_data, 32'hDEAD_BEEF);
        chk("wl_wr", o_wr, 32'd1);

        // Signed byte load from lane 3 with three wait cycles.
        issue(mk(1'b1, 1'b0, MASK_B, 32'h103, '0, 32'h8012_3456, 1'b1, 1'b1, 32'h0, 3));
        run_cur();
        chk("sb_stalls", o_stalls, 32'd3);
        chk("sb_data", o_data, 32'hFFFF_FF80);
        chk("sb_wr", o_wr, 32'd1);
        chk("sb_wr_in_stall", o_wr_in_stall, 32'd0);

        // Half store to the upper half-word.
        issue(mk(1'b0, 1'b1, MASK_H, 32'h202, 32'h1234_ABCD, '0, 1'b0, 1'b0, 32'h0, 0));
        run_cur();
        chk("hs_addr", o_addr, 32'h200);
        chk("hs_wdata", o_wdata, 32'hABCD_ABCD);
        chk("hs_wstrb", o_strb, 32'hC);
        chk("hs_we", o_we, 32'd1);

        // Misaligned word load, then flag persists.
        issue(mk(1'b1, 1'b0, MASK_W, 32'h101, '0, 32'h5555_5555, 1'b0, 1'b1, 32'h0, 0));
        run_cur();
        chk("mis_req", o_req_seen, 32'd0);
        chk("mis_wr", o_wr, 32'd0);
        issue(filler());
        run_cur();
        issue(filler());
        run_cur();
        chk("mis_sticky", o_mis, 32'd1);

        // Timeout: ready never arrives.
        issue(mk(1'b1, 1'b0, MASK_W, 32'h300, '0, '0, 1'b0, 1'b1, 32'h0, 50));
        run_cur();
        chk("to_stalls", o_stalls, TO);
        chk("to_wr", o_wr, 32'd0);
        issue(mk(1'b0, 1'b0, MASK_W, 32'h0, '0, '0, 1'b0, 1'b1, 32'h55, 0));
        run_cur();
        chk("to_next_wr", o_wr, 32'd1);
        chk("to_next_data", o_data, 32'h55);
        chk("to_bus_err", o_berr, 32'd1);

        // Random traffic.
        nxt = gen();
        repeat (1500) begin
            step();
            if (consumed) nxt = gen();
        end

        // Reset while waiting.
        issue(mk(1'b1, 1'b0, MASK_W, 32'h400, '0, '0, 1'b0, 1'b1, 32'h0, 50));
        step();
        step();
        @(negedge clk);
        model_on = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("mw_req_before", dmem_req, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mw_req", dmem_req, 32'd0);
        chk("mw_stall", stall, 32'd0);
        chk("mw_regcWr", regcWr, 32'd0);
        chk("mw_regcData", regcData, 32'h0);
        chk("mw_flags", {misalign, bus_err}, 32'h0);
        chk("mw_inst_debug", inst_debug, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cur = bubble();
        cyc = 0;
        mis_seen = 1'b0;
        berr_seen = 1'b0;
        nxt = filler();

        // FSM must be idle again: a zero-wait load completes without stalling.
        issue(mk(1'b1, 1'b0, MASK_W, 32'h500, '0, 32'h1122_3344, 1'b0, 1'b1, 32'h0, 0));
        run_cur();
        chk("pr_stalls", o_stalls, 32'd0);
        chk("pr_data", o_data, 32'h1122_3344);
        chk("pr_wr", o_wr, 32'd1);

        @(negedge clk);
        model_on = 1'b0;
        #5;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
